note_priority_arbiter: RTL and testbench

//  Shares the single square-wave voice between 12 keyboard keys.
//  - Synchronises and debounces each key.
//  - Keeps a last-pressed-priority stack of held keys; the top entry owns the voice.
//  - Drives the registered half-period (sample-clock units) to the tone generator ahead of i2s_transmitter.
//  - On release of the top key, falls back to the most recent key still held.

---
 rtl/synth_pkg.sv | 30 +++
 rtl/note_priority_arbiter_if.sv | 13 +
 rtl/note_priority_arbiter_key_debouncer.sv | 47 ++++
 rtl/note_priority_arbiter.sv | 152 +++++++++++++++
 tb/tb_note_priority_arbiter.sv | 158 +++++++++++++++
 5 files changed

// File: rtl/synth_pkg.sv
// Shared types and constants for the keyboard voice arbiter.
// Half-periods are in 48 kHz sample-clock units for the square-wave tone generator.
package synth_pkg;

  localparam int NUM_KEYS = 12;

  typedef logic [3:0] note_idx_t;

  typedef enum logic [1:0] {
    IDLE,
    SCAN,
    UPDATE
  } arb_state_t;

  // C4..B4
  localparam logic [7:0] HALF_PERIOD_LUT [NUM_KEYS] = '{
    8'd92, 8'd87, 8'd82, 8'd77, 8'd73, 8'd69,
    8'd65, 8'd61, 8'd58, 8'd55, 8'd51, 8'd49
  };

  function automatic logic [7:0] half_period_of(note_idx_t idx);
    logic [7:0] hp;
    hp = 8'd0;
    for (int i = 0; i < NUM_KEYS; i++) begin
      if (idx == 4'(i)) hp = HALF_PERIOD_LUT[i];
    end
    return hp;
  endfunction

endpackage

// File: rtl/note_priority_arbiter_if.sv
// Voice-ownership bus from the arbiter to the tone generator.
interface note_priority_arbiter_if;
  import synth_pkg::*;

  note_idx_t   note_idx;
  logic        note_valid;
  logic [7:0]  half_period;
  logic        note_change;

  modport master (output note_idx, output note_valid, output half_period, output note_change);
  modport slave  (input  note_idx, input  note_valid, input  half_period, input  note_change);

endinterface

// File: rtl/note_priority_arbiter_key_debouncer.sv
// Per-key synchroniser and debouncer; emits a one-clk press or release strobe
// once a new level has been stable for DEBOUNCE_TICKS sample ticks.
module key_debouncer #(
  parameter int DEBOUNCE_TICKS = 240
) (
  input  logic clk,
  input  logic rst,
  input  logic sample_tick,
  input  logic key_raw,
  output logic press_evt,
  output logic release_evt
);

  localparam int CW = $clog2(DEBOUNCE_TICKS + 1);

  logic          meta;
  logic          sync;
  logic          level;
  logic [CW-1:0] cnt;
  logic          accept;

  assign accept = sample_tick && (sync != level) && (cnt == CW'(DEBOUNCE_TICKS - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta  <= 1'b0;
      sync  <= 1'b0;
      level <= 1'b0;
      cnt   <= '0;
    end else begin
      meta <= key_raw;
      sync <= meta;
      if (sync == level) begin
        cnt <= '0;
      end else if (accept) begin
        level <= sync;
        cnt   <= '0;
      end else if (sample_tick) begin
        cnt <= cnt + CW'(1);
      end
    end
  end

  assign press_evt   = accept && sync;
  assign release_evt = accept && !sync;

endmodule

// File: rtl/note_priority_arbiter.sv
// Last-pressed-priority arbiter: a stack of held keys, the top entry owns the
// single square-wave voice. A scan FSM folds pending key events into the stack.
module note_priority_arbiter
  import synth_pkg::*;
#(
  parameter int DEBOUNCE_TICKS = 240
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                sample_tick,
  input  logic [NUM_KEYS-1:0] keys,
  note_priority_arbiter_if.master voice
);

  logic [NUM_KEYS-1:0] press_evt, release_evt;
  logic [NUM_KEYS-1:0] pend, pend_press, pend_clr;

  for (genvar k = 0; k < NUM_KEYS; k++) begin : g_deb
    key_debouncer #(.DEBOUNCE_TICKS(DEBOUNCE_TICKS)) u_deb (
      .clk         (clk),
      .rst         (rst),
      .sample_tick (sample_tick),
      .key_raw     (keys[k]),
      .press_evt   (press_evt[k]),
      .release_evt (release_evt[k])
    );
  end

  // A new event in the same clk as its clear keeps the flag set.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pend       <= '0;
      pend_press <= '0;
    end else begin
      for (int k = 0; k < NUM_KEYS; k++) begin
        if (press_evt[k] || release_evt[k]) begin
          pend[k]       <= 1'b1;
          pend_press[k] <= press_evt[k];
        end else if (pend_clr[k]) begin
          pend[k] <= 1'b0;
        end
      end
    end
  end

  arb_state_t state, state_nxt;
  note_idx_t  scan_k, scan_nxt;
  note_idx_t  stack [NUM_KEYS];
  note_idx_t  stack_nxt [NUM_KEYS];
  note_idx_t  stack_rm [NUM_KEYS];
  logic [4:0] depth, depth_nxt, depth_rm, depth_m1;
  logic       found;
  logic       upd;
  note_idx_t  top_idx;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      scan_k <= '0;
      depth  <= '0;
      for (int i = 0; i < NUM_KEYS; i++) stack[i] <= '0;
    end else begin
      state  <= state_nxt;
      scan_k <= scan_nxt;
      depth  <= depth_nxt;
      for (int i = 0; i < NUM_KEYS; i++) stack[i] <= stack_nxt[i];
    end
  end

  // Entry depth-1 is the top; removal shifts the newer entries down by one.
  always_comb begin
    state_nxt = state;
    scan_nxt  = scan_k;
    depth_nxt = depth;
    pend_clr  = '0;
    upd       = 1'b0;
    found     = 1'b0;
    stack_rm  = stack;
    stack_nxt = stack;
    depth_rm  = depth;
    for (int i = 0; i < NUM_KEYS - 1; i++) begin
      if (5'(i) < depth && stack[i] == scan_k) found = 1'b1;
      if (found) stack_rm[i] = stack[i + 1];
    end
    if (depth == 5'(NUM_KEYS) && stack[NUM_KEYS-1] == scan_k) found = 1'b1;
    if (found) depth_rm = depth - 5'd1;

    case (state)
      IDLE: begin
        if (|pend) begin
          state_nxt = SCAN;
          scan_nxt  = '0;
        end
      end
      SCAN: begin
        if (pend[scan_k]) begin
          pend_clr[scan_k] = 1'b1;
          stack_nxt        = stack_rm;
          depth_nxt        = depth_rm;
          if (pend_press[scan_k]) begin
            stack_nxt[depth_rm[3:0]] = scan_k;
            depth_nxt                = depth_rm + 5'd1;
          end
        end
        if (scan_k == 4'(NUM_KEYS - 1)) state_nxt = UPDATE;
        else                            scan_nxt  = scan_k + 4'd1;
      end
      UPDATE: begin
        upd       = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign depth_m1 = depth - 5'd1;
  assign top_idx  = stack[depth_m1[3:0]];

  note_idx_t  note_idx_q;
  logic       note_valid_q;
  logic [7:0] half_period_q;
  logic       note_change_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      note_idx_q    <= '0;
      note_valid_q  <= 1'b0;
      half_period_q <= '0;
      note_change_q <= 1'b0;
    end else begin
      note_change_q <= 1'b0;
      if (upd) begin
        if (depth != 5'd0) begin
          note_idx_q    <= top_idx;
          note_valid_q  <= 1'b1;
          half_period_q <= half_period_of(top_idx);
          note_change_q <= ({1'b1, top_idx} != {note_valid_q, note_idx_q});
        end else begin
          note_valid_q  <= 1'b0;
          half_period_q <= '0;
          note_change_q <= note_valid_q;
        end
      end
    end
  end

  assign voice.note_idx    = note_idx_q;
  assign voice.note_valid  = note_valid_q;
  assign voice.half_period = half_period_q;
  assign voice.note_change = note_change_q;

endmodule

// File: tb/tb_note_priority_arbiter.sv
// Scoreboard bench: expected voice changes are queued with each stimulus and
// popped by a monitor on every note_change pulse.
module tb_note_priority_arbiter;
  import synth_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        sample_tick = 1'b0;
  logic [11:0] keys = '0;

  note_priority_arbiter_if voice();

  note_priority_arbiter #(.DEBOUNCE_TICKS(4)) dut (
    .clk         (clk),
    .rst         (rst),
    .sample_tick (sample_tick),
    .keys        (keys),
    .voice       (voice)
  );

  always #5 clk = ~clk;

  int tick_div = 0;
  always @(negedge clk) begin
    tick_div    = (tick_div == 255) ? 0 : tick_div + 1;
    sample_tick = (tick_div == 255);
  end

  logic [12:0] exp_q [$];
  int n_cmp = 0;
  int n_bad = 0;

  always @(negedge clk) begin
    logic [12:0] e;
    if (!rst && voice.note_change) begin
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_bad++;
        $display("FAIL unexpected_note_change: got idx=%0d valid=%0b hp=%0d, required no pulse",
                 voice.note_idx, voice.note_valid, voice.half_period);
      end else begin
        e = exp_q.pop_front();
        if ({voice.note_idx, voice.note_valid, voice.half_period} !== e) begin
          n_bad++;
          $display("FAIL note_change_values: got idx=%0d valid=%0b hp=%0d, required idx=%0d valid=%0b hp=%0d",
                   voice.note_idx, voice.note_valid, voice.half_period, e[12:9], e[8], e[7:0]);
        end
      end
    end
  end

  task automatic expect_note(input int idx, input int valid, input int hp);
    exp_q.push_back({4'(idx), 1'(valid), 8'(hp)});
  endtask

  task automatic check(input string name, input int act, input int req);
    n_cmp++;
    if (act != req) begin
      n_bad++;
      $display("FAIL %s: got %0d, required %0d", name, act, req);
    end
  endtask

  task automatic check_outs(input string name, input int idx, input int valid, input int hp);
    @(negedge clk);
    check({name, "_idx"}, int'(voice.note_idx), idx);
    check({name, "_valid"}, int'(voice.note_valid), valid);
    check({name, "_hp"}, int'(voice.half_period), hp);
  endtask

  task automatic drain(input string name);
    int budget;
    budget = 3000;
    while (exp_q.size() != 0 && budget > 0) begin
      @(negedge clk);
      budget--;
    end
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL %s: %0d expected note changes still pending, required 0", name, exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic wait_tick();
    @(posedge clk iff sample_tick);
    #1;
  endtask

  initial begin
    #950000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1);
  end

  initial begin
    repeat (3) @(negedge clk);
    check("reset_change", int'(voice.note_change), 0);
    check_outs("reset", 0, 0, 0);
    rst = 1'b0;
    repeat (6) wait_tick();
    check_outs("idle", 0, 0, 0);

    // single key
    wait_tick();
    expect_note(9, 1, 55); keys[9] = 1'b1; drain("key9_press");
    check_outs("key9", 9, 1, 55);
    expect_note(9, 0, 0); keys[9] = 1'b0; drain("key9_release");
    check_outs("key9_off", 9, 0, 0);

    // fallback to an earlier held key
    expect_note(0, 1, 92); keys[0] = 1'b1; drain("key0_press");
    expect_note(4, 1, 73); keys[4] = 1'b1; drain("key4_press");
    check_outs("key4", 4, 1, 73);
    expect_note(0, 1, 92); keys[4] = 1'b0; drain("key4_release");
    check_outs("fallback0", 0, 1, 92);
    expect_note(0, 0, 0); keys[0] = 1'b0; drain("key0_release");

    // simultaneous presses: highest index ends on top
    expect_note(7, 1, 61); keys = keys | 12'h084; drain("keys2_7_press");
    check_outs("simul", 7, 1, 61);
    expect_note(2, 1, 82); keys[7] = 1'b0; drain("key7_release");
    check_outs("fallback2", 2, 1, 82);
    expect_note(2, 0, 0); keys[2] = 1'b0; drain("key2_release");

    // bounce shorter than the debounce window
    expect_note(0, 1, 92); keys[0] = 1'b1; drain("key0_hold");
    for (int t = 0; t < 10; t++) begin
      keys[5] = ~keys[5];
      wait_tick();
      wait_tick();
    end
    repeat (6) wait_tick();
    check_outs("bounce", 0, 1, 92);
    expect_note(0, 0, 0); keys[0] = 1'b0; drain("key0_off");

    // reset in the middle of a scan
    expect_note(11, 1, 49); keys[11] = 1'b1; drain("key11_press");
    wait_tick();
    keys = 12'h00A;
    repeat (4) wait_tick();
    repeat (5) @(posedge clk);
    #1 rst = 1'b1;
    check_outs("midscan_rst", 0, 0, 0);
    check("midscan_rst_change", int'(voice.note_change), 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    expect_note(3, 1, 77); drain("redebounce");
    check_outs("redebounce", 3, 1, 77);

    repeat (4) wait_tick();
    check("queue_empty", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
